// File: rtl/fft_frame_packer.sv
// fft_frame_packer: packs a stream of real samples into complex FFT input
// words, buffers them in a small elastic FIFO and frames them into runs of
// NUM_FRAMES frames of NFFT samples for an AXI-Stream style FFT core.
module fft_frame_packer #(
  parameter int NFFT       = 1024,
  parameter int NUM_FRAMES = 8,
  parameter int BUF_DEPTH  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] data_in,
  input  logic               data_valid,
  output logic [31:0]        m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic [3:0]         frame_idx,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int TOTAL = NUM_FRAMES * NFFT;
  localparam int WCW   = $clog2(TOTAL + 1);

  localparam logic [AW:0]     FULL_OCC   = (AW+1)'(BUF_DEPTH);
  localparam logic [AW:0]     ONE_OCC    = (AW+1)'(1);
  localparam logic [11:0]     LAST_CNT   = 12'(NFFT - 1);
  localparam logic [3:0]      LAST_FRAME = 4'(NUM_FRAMES - 1);
  localparam logic [WCW-1:0]  LAST_WR    = WCW'(TOTAL - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    STREAM = 4'b0010,
    DRAIN  = 4'b0100,
    DONE   = 4'b1000
  } state_t;

  state_t state, state_nxt;

  // FIFO storage and bookkeeping; occ counts every entry including the one
  // currently presented on the output register.
  logic [31:0]    mem [BUF_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, rd_sel;
  logic [AW:0]    occ;
  logic           head_avail;

  // Registered head of the FIFO (output stage)
  logic [31:0]    head_p1;
  logic           vld_p1;

  logic [11:0]    sample_cnt;
  logic [WCW-1:0] wr_cnt;
  logic           ovf_q;

  logic           xfer, accept, full, wr_en, drop, start, last_xfer, final_xfer;

  // Real sample into the real lane, imaginary lane zero.
  function automatic logic [31:0] pack_word(input logic signed [15:0] s);
    return {16'h0000, s};
  endfunction

  assign xfer       = vld_p1 & m_tready;
  assign accept     = data_valid & ((state == IDLE) | (state == STREAM));
  assign full       = (occ == FULL_OCC);
  assign wr_en      = accept & (~full | xfer);
  assign drop       = accept & full & ~xfer;
  assign start      = (state == IDLE) & data_valid;
  assign last_xfer  = xfer & m_tlast;
  assign final_xfer = last_xfer & (frame_idx == LAST_FRAME);

  assign m_tdata  = head_p1;
  assign m_tvalid = vld_p1;
  assign m_tlast  = vld_p1 & (sample_cnt == LAST_CNT);
  assign busy     = (state == STREAM) | (state == DRAIN);
  assign done     = (state == DONE);
  assign overflow = ovf_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the empty-buffer exit only applies once samples were
  // dropped, since then the last frame may never complete.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (data_valid) state_nxt = STREAM;
      STREAM:  if (data_valid && (wr_cnt == LAST_WR)) state_nxt = DRAIN;
      DRAIN:   if (final_xfer || (ovf_q && (occ == '0))) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO sample storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= pack_word(data_in);
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (xfer)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, xfer})
        2'b10:   occ <= occ + ONE_OCC;
        2'b01:   occ <= occ - ONE_OCC;
        default: occ <= occ;
      endcase
    end
  end

  // Pick the entry that becomes the head: the next one after a transfer,
  // otherwise the current one. Only entries written before this edge count,
  // so a fresh write never shows up until the following edge.
  always_comb begin
    rd_sel     = rd_ptr;
    head_avail = (occ != '0);
    if (xfer) begin
      rd_sel     = rd_ptr + 1'b1;
      head_avail = (occ > ONE_OCC);
    end
  end

  // ---- stage p1: registered FIFO head, held while stalled ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      head_p1 <= '0;
    end else if (!vld_p1 || xfer) begin
      vld_p1 <= head_avail;
      if (head_avail) head_p1 <= mem[rd_sel];
    end
  end

  // Sample position within frame and frame index, advanced by transfers
  always_ff @(posedge clk) begin
    if (rst || start) begin
      sample_cnt <= '0;
      frame_idx  <= '0;
    end else if (xfer) begin
      if (m_tlast) begin
        sample_cnt <= '0;
        frame_idx  <= (frame_idx == LAST_FRAME) ? 4'd0 : frame_idx + 4'd1;
      end else begin
        sample_cnt <= sample_cnt + 12'd1;
      end
    end
  end

  // Samples consumed this run (written or dropped) and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      ovf_q  <= 1'b0;
    end else if (start) begin
      wr_cnt <= WCW'(1);
      ovf_q  <= 1'b0;
    end else begin
      if ((state == STREAM) && data_valid) wr_cnt <= wr_cnt + 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_packer.sv
// Bench for fft_frame_packer: randomized and directed runs with a scoreboard
// fed by the stimulus side and drained by an independent output monitor.
module tb_fft_frame_packer;

  localparam int NFFT  = 1024;
  localparam int NF    = 8;
  localparam int BD    = 16;
  localparam int TOTAL = NFFT * NF;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] data_in;
  logic               data_valid;
  logic [31:0]        m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_tlast;
  logic [3:0]         frame_idx;
  logic               busy;
  logic               done;
  logic               overflow;

  always #5 clk = ~clk;

  fft_frame_packer #(.NFFT(NFFT), .NUM_FRAMES(NF), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .frame_idx(frame_idx), .busy(busy), .done(done),
    .overflow(overflow)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  frame;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int mode = 0;       // 0: lossless scoreboard, 1: lossy ordering checks
  int xfer_n = 0;
  int done_cnt = 0;
  int run_n = 0;
  int prev_real = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every handshake is checked against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (m_tvalid && m_tready) begin
        if (mode == 0) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_xfer: got %0h expected no transfer", m_tdata);
          end else begin
            e = sb.pop_front();
            chk("tdata", m_tdata, e.data);
            chk("tlast", 32'(m_tlast), 32'(e.last));
            chk("frame_idx", 32'(frame_idx), 32'(e.frame));
          end
        end else begin
          chk("imag_zero", 32'(m_tdata[31:16]), 32'd0);
          total++;
          if (int'($signed(m_tdata[15:0])) <= prev_real) begin
            bad++;
            $display("FAIL order: got %0d expected above %0d", $signed(m_tdata[15:0]), prev_real);
          end
          prev_real = int'($signed(m_tdata[15:0]));
          chk("lossy_tlast", 32'(m_tlast), 32'((xfer_n % NFFT) == NFFT - 1));
          chk("lossy_frame", 32'(frame_idx), 32'(xfer_n / NFFT));
        end
        xfer_n++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic dv, input logic signed [15:0] d, input logic rdy);
    data_valid = dv;
    data_in    = d;
    m_tready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] v, input logic rdy);
    exp_t x;
    if (mode == 0) begin
      x.data  = {16'h0000, v};
      x.last  = ((run_n % NFFT) == NFFT - 1);
      x.frame = 4'(run_n / NFFT);
      sb.push_back(x);
    end
    run_n++;
    cyc(1'b1, v, rdy);
  endtask

  task automatic start_run(input int m);
    mode      = m;
    xfer_n    = 0;
    run_n     = 0;
    done_cnt  = 0;
    prev_real = -1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_tlast"}, 32'(m_tlast), 32'd0);
    chk({tag, "_tdata"}, m_tdata, 32'd0);
    chk({tag, "_frame"}, 32'(frame_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  task automatic wait_done(input logic dv_junk, input logic toggle, input logic exp_ov);
    int k;
    k = 0;
    while (!done && k < 20000) begin
      cyc(dv_junk, 16'sh7abc, toggle ? logic'(k[0]) : 1'b1);
      k++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done within 20000 cycles");
    end
    chk("overflow_at_done", 32'(overflow), 32'(exp_ov));
    cyc(dv_junk, 16'sh7abc, 1'b1);
    repeat (3) cyc(1'b0, 16'sh0, 1'b1);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    if (mode == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("xfer_count", 32'(xfer_n), 32'(TOTAL));
    end else begin
      total++;
      if (!(xfer_n > 0 && xfer_n < TOTAL)) begin
        bad++;
        $display("FAIL lossy_count: got %0d expected between 1 and %0d", xfer_n, TOTAL - 1);
      end
    end
  endtask

  logic [31:0] cap_d;
  logic        cap_l;
  int          stall_at;
  bit          gap_done;

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    m_tready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst0");
    rst = 1'b0;

    // Partial run aborted by reset after 3000 samples
    start_run(0);
    for (int i = 0; i < 3000; i++) send(16'(i + 1), 1'b1);
    data_valid = 1'b0;
    m_tready   = 1'b0;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    reset_checks("rst_mid");
    rst = 1'b0;
    sb.delete();

    // Full ramp run, always ready; junk offered during drain and done
    start_run(0);
    send(16'sd1, 1'b1);
    chk("latency_n", 32'(m_tvalid), 32'd0);
    send(16'sd2, 1'b1);
    chk("latency_n1", 32'(m_tvalid), 32'd1);
    chk("first_word", m_tdata, 32'h0000_0001);
    for (int i = 2; i < TOTAL; i++) send(16'(i + 1), 1'b1);
    wait_done(1'b1, 1'b0, 1'b0);

    // Random data: fill buffer, hold full with simultaneous read/write,
    // then random gaps, a long gap and 5-cycle stalls
    start_run(0);
    for (int i = 0; i < BD; i++) send(16'($urandom), 1'b0);
    cyc(1'b0, 16'sh0, 1'b0);
    chk("full_pre_ovf", 32'(overflow), 32'd0);
    chk("full_pre_vld", 32'(m_tvalid), 32'd1);
    for (int i = 0; i < 20; i++) send(16'($urandom), 1'b1);
    chk("full_rw_ovf", 32'(overflow), 32'd0);
    gap_done = 1'b0;
    stall_at = -1;
    while (run_n < TOTAL) begin
      if (run_n == 1500 && !gap_done) begin
        gap_done = 1'b1;
        for (int g = 0; g < 100; g++) begin
          cyc(1'b0, 16'sh0, 1'b1);
          chk("gap_busy", 32'(busy), 32'd1);
        end
      end else if ((run_n == 3000 || run_n == 6000) && stall_at != run_n) begin
        stall_at = run_n;
        send(16'($urandom), 1'b0);
        cyc(1'b0, 16'sh0, 1'b0);
        chk("stall_vld", 32'(m_tvalid), 32'd1);
        cap_d = m_tdata;
        cap_l = m_tlast;
        for (int s = 0; s < 5; s++) begin
          send(16'($urandom), 1'b0);
          chk("stall_tdata", m_tdata, cap_d);
          chk("stall_tlast", 32'(m_tlast), 32'(cap_l));
          chk("stall_tvalid", 32'(m_tvalid), 32'd1);
        end
      end else if ($urandom_range(0, 1) == 1) begin
        send(16'($urandom), 1'b1);
      end else begin
        cyc(1'b0, 16'sh0, 1'b1);
      end
    end
    wait_done(1'b0, 1'b0, 1'b0);

    // Ready toggling with continuous input: overflow, drain exits on empty
    start_run(1);
    for (int i = 0; i < TOTAL; i++) send(16'(i + 1), logic'(i[0]));
    wait_done(1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
